// File: rtl/chan_arbiter.sv
// rtl/chan_arbiter.sv - per-channel sample holding registers arbitrated onto one output stream
module chan_arbiter #(
  parameter int N_CHAN       = 5,
  parameter int W_CHAN       = 8,
  parameter int W_DATA       = 18,
  parameter int W_WR_ADDR    = 16,
  parameter int W_WR_CHAN    = 16,
  parameter int W_WR_DATA    = 48,
  parameter int ADDR_CHAN_EN = 'h0001,
  parameter int ADDR_OVF_CLR = 'h0002,
  parameter int RR_MODE      = 1
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic [N_CHAN-1:0]          dv_in,
  input  logic [N_CHAN*W_DATA-1:0]   data_in,
  input  logic                       wr_en,
  input  logic [W_WR_ADDR-1:0]       wr_addr,
  input  logic [W_WR_CHAN-1:0]       wr_chan,
  input  logic [W_WR_DATA-1:0]       wr_data,
  output logic                       dv_out,
  output logic [W_CHAN-1:0]          chan_out,
  output logic signed [W_DATA-1:0]   data_out,
  output logic [N_CHAN-1:0]          chan_en_out,
  output logic [N_CHAN-1:0]          ovf_out
);

  localparam int W_IDX = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;

  logic [W_DATA-1:0]        r_hold [N_CHAN];
  logic [N_CHAN-1:0]        r_valid;
  logic [N_CHAN-1:0]        r_chan_en;
  logic [N_CHAN-1:0]        r_ovf;
  logic [W_IDX-1:0]         r_last_grant;
  logic                     r_dv_out;
  logic [W_CHAN-1:0]        r_chan_out;
  logic signed [W_DATA-1:0] r_data_out;

  logic [N_CHAN-1:0]        w_grant_vec;
  logic                     w_grant_any;
  logic [W_IDX-1:0]         w_grant_idx;
  logic [N_CHAN-1:0]        w_wr_sel;
  logic [N_CHAN-1:0]        w_ovf_evt;
  logic                     w_wr_chan_ok;
  logic                     w_cfg_en_hit;
  logic                     w_cfg_clr_hit;
  logic                     w_unused;

  // Only bit 0 of the write data carries meaning (enable value)
  assign w_unused = ^wr_data;

  assign w_wr_chan_ok  = (wr_chan < W_WR_CHAN'(N_CHAN));
  assign w_cfg_en_hit  = wr_en && (wr_addr == W_WR_ADDR'(ADDR_CHAN_EN)) && w_wr_chan_ok;
  assign w_cfg_clr_hit = wr_en && (wr_addr == W_WR_ADDR'(ADDR_OVF_CLR)) && w_wr_chan_ok;

  // Pick at most one valid holding register: round-robin after last grant, or lowest index
  always_comb begin
    int idx;
    w_grant_vec = '0;
    w_grant_any = 1'b0;
    w_grant_idx = '0;
    idx         = 0;
    if (RR_MODE != 0) begin
      for (int k = 1; k <= N_CHAN; k++) begin
        idx = int'(r_last_grant) + k;
        if (idx >= N_CHAN) idx = idx - N_CHAN;
        if (!w_grant_any && r_valid[W_IDX'(idx)]) begin
          w_grant_any = 1'b1;
          w_grant_idx = W_IDX'(idx);
        end
      end
    end else begin
      for (int i = N_CHAN - 1; i >= 0; i--) begin
        if (r_valid[i]) begin
          w_grant_any = 1'b1;
          w_grant_idx = W_IDX'(i);
        end
      end
    end
    if (w_grant_any) w_grant_vec[w_grant_idx] = 1'b1;
  end

  // Per-channel write select and overflow event (strobe onto a held, ungranted sample)
  always_comb begin
    w_wr_sel  = '0;
    w_ovf_evt = '0;
    for (int i = 0; i < N_CHAN; i++) begin
      w_wr_sel[i]  = (wr_chan == W_WR_CHAN'(i));
      w_ovf_evt[i] = r_chan_en[i] && dv_in[i] && r_valid[i] && !w_grant_vec[i];
    end
  end

  // Holding registers, config registers, overflow flags and registered output stage
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_valid      <= '0;
      r_chan_en    <= '0;
      r_ovf        <= '0;
      r_last_grant <= W_IDX'(N_CHAN - 1);
      r_dv_out     <= 1'b0;
      r_chan_out   <= '0;
      r_data_out   <= '0;
      for (int i = 0; i < N_CHAN; i++) r_hold[i] <= '0;
    end else begin
      if (w_grant_any) begin
        r_dv_out     <= 1'b1;
        r_chan_out   <= W_CHAN'(w_grant_idx);
        r_data_out   <= r_hold[w_grant_idx];
        r_last_grant <= w_grant_idx;
      end else begin
        r_dv_out <= 1'b0;
      end
      for (int i = 0; i < N_CHAN; i++) begin
        // A disabled channel drops its sample, but a grant already made this cycle still goes out
        if (!r_chan_en[i]) begin
          r_valid[i] <= 1'b0;
        end else if (dv_in[i]) begin
          r_hold[i]  <= data_in[i*W_DATA +: W_DATA];
          r_valid[i] <= 1'b1;
        end else if (w_grant_vec[i]) begin
          r_valid[i] <= 1'b0;
        end
        if (w_cfg_en_hit && w_wr_sel[i]) r_chan_en[i] <= wr_data[0];
        // A fresh overflow beats a coincident clear so no event is lost
        if (w_ovf_evt[i]) r_ovf[i] <= 1'b1;
        else if (w_cfg_clr_hit && w_wr_sel[i]) r_ovf[i] <= 1'b0;
      end
    end
  end

  assign dv_out      = r_dv_out;
  assign chan_out    = r_chan_out;
  assign data_out    = r_data_out;
  assign chan_en_out = r_chan_en;
  assign ovf_out     = r_ovf;

endmodule

// File: tb/tb_chan_arbiter.sv
// tb/tb_chan_arbiter.sv - directed self-checking bench for chan_arbiter in both arbitration modes
module tb_chan_arbiter;

  localparam int N  = 5;
  localparam int WD = 18;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  dv;
  logic [N*WD-1:0] din;
  logic          wr_en;
  logic [15:0]   wr_addr;
  logic [15:0]   wr_chan;
  logic [47:0]   wr_data;

  logic          rr_dv, fp_dv;
  logic [7:0]    rr_chan, fp_chan;
  logic [WD-1:0] rr_data, fp_data;
  logic [N-1:0]  rr_en, fp_en, rr_ovf, fp_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  chan_arbiter #(.RR_MODE(1)) u_rr (
    .clk_in(clk), .rst_in(rst), .dv_in(dv), .data_in(din),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_chan(wr_chan), .wr_data(wr_data),
    .dv_out(rr_dv), .chan_out(rr_chan), .data_out(rr_data),
    .chan_en_out(rr_en), .ovf_out(rr_ovf)
  );

  chan_arbiter #(.RR_MODE(0)) u_fp (
    .clk_in(clk), .rst_in(rst), .dv_in(dv), .data_in(din),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_chan(wr_chan), .wr_data(wr_data),
    .dv_out(fp_dv), .chan_out(fp_chan), .data_out(fp_data),
    .chan_en_out(fp_en), .ovf_out(fp_ovf)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [15:0] a, input logic [15:0] c, input logic [47:0] d);
    wr_en = 1'b1; wr_addr = a; wr_chan = c; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; dv = '0; din = '0; wr_en = 1'b0; wr_addr = '0; wr_chan = '0; wr_data = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_d(input int ch, input logic [WD-1:0] v);
    din[ch*WD +: WD] = v;
  endtask

  initial begin
    do_reset();
    check_eq("rst_dv", rr_dv, 0);
    check_eq("rst_chan", rr_chan, 0);
    check_eq("rst_data", rr_data, 0);
    check_eq("rst_en", rr_en, 0);
    check_eq("rst_ovf", rr_ovf, 0);

    // single uncontended sample, latency two cycles
    cfg_write(16'h0001, 16'd2, 48'd1);
    check_eq("en_ch2", rr_en, 5'b00100);
    dv = 5'b00100; set_d(2, 18'h1234);
    tick();
    dv = '0;
    check_eq("lat_t1_dv", rr_dv, 0);
    tick();
    check_eq("lat_t2_dv", rr_dv, 1);
    check_eq("lat_t2_chan", rr_chan, 2);
    check_eq("lat_t2_data", rr_data, 18'h1234);
    tick();
    check_eq("lat_t3_dv", rr_dv, 0);
    check_eq("lat_t3_hold", rr_chan, 2);

    // round-robin drain of five simultaneous samples
    do_reset();
    for (int i = 0; i < N; i++) cfg_write(16'h0001, 16'(i), 48'd1);
    check_eq("en_all", rr_en, 5'b11111);
    dv = 5'b11111;
    for (int i = 0; i < N; i++) set_d(i, 18'(18'h100 + i));
    tick();
    dv = '0;
    check_eq("rr_t1_dv", rr_dv, 0);
    for (int k = 0; k < N; k++) begin
      tick();
      check_eq($sformatf("rr_dv%0d", k), rr_dv, 1);
      check_eq($sformatf("rr_chan%0d", k), rr_chan, k);
      check_eq($sformatf("rr_data%0d", k), rr_data, 18'h100 + k);
    end
    tick();
    check_eq("rr_end_dv", rr_dv, 0);
    check_eq("rr_ovf", rr_ovf, 0);

    // fixed priority: ch0 and ch3 strobed every cycle
    do_reset();
    cfg_write(16'h0001, 16'd0, 48'd1);
    cfg_write(16'h0001, 16'd3, 48'd1);
    for (int k = 0; k <= 8; k++) begin
      if (k < 6) begin
        dv = 5'b01001;
        set_d(0, 18'(18'h10 + k));
        set_d(3, 18'(18'h30 + k));
      end else begin
        dv = '0;
      end
      if (k >= 2 && k <= 7) begin
        check_eq($sformatf("fp_dv%0d", k), fp_dv, 1);
        check_eq($sformatf("fp_chan%0d", k), fp_chan, 0);
        check_eq($sformatf("fp_data%0d", k), fp_data, 18'h10 + (k - 2));
      end else if (k == 8) begin
        check_eq("fp_tail_chan", fp_chan, 3);
        check_eq("fp_tail_data", fp_data, 18'h35);
      end
      tick();
    end
    check_eq("fp_end_dv", fp_dv, 0);
    check_eq("fp_ovf3", fp_ovf[3], 1);
    check_eq("fp_ovf0", fp_ovf[0], 0);

    // disabled channel ignored; out-of-range enable write ignored
    do_reset();
    dv = 5'b00010; set_d(1, 18'h77);
    tick();
    dv = '0;
    check_eq("dis_t1_dv", rr_dv, 0);
    tick();
    check_eq("dis_t2_dv", rr_dv, 0);
    check_eq("dis_t2_fpdv", fp_dv, 0);
    check_eq("dis_ovf", rr_ovf, 0);
    cfg_write(16'h0001, 16'd0, 48'd1);
    check_eq("en_ch0", rr_en, 5'b00001);
    cfg_write(16'h0001, 16'd7, 48'd1);
    check_eq("en_ch7_ign", rr_en, 5'b00001);

    // overflow set wins over coincident clear; clear alone works
    do_reset();
    cfg_write(16'h0001, 16'd3, 48'd1);
    cfg_write(16'h0001, 16'd4, 48'd1);
    dv = 5'b11000; set_d(3, 18'h3); set_d(4, 18'h4);
    tick();
    tick();
    check_eq("ovf4_set", fp_ovf[4], 1);
    wr_en = 1'b1; wr_addr = 16'h0002; wr_chan = 16'd4; wr_data = '0;
    tick();
    check_eq("ovf4_race", fp_ovf[4], 1);
    dv = '0;
    tick();
    wr_en = 1'b0;
    check_eq("ovf4_clr", fp_ovf, 5'b00000);

    // asynchronous reset mid-stream
    do_reset();
    for (int i = 0; i < 3; i++) cfg_write(16'h0001, 16'(i), 48'd1);
    dv = 5'b00111;
    set_d(0, 18'h2AAAA); set_d(1, 18'h11); set_d(2, 18'h22);
    tick();
    dv = '0;
    tick();
    check_eq("ar_pre_data", rr_data, 18'h2AAAA);
    #1 rst = 1'b1;
    #1;
    check_eq("ar_dv", rr_dv, 0);
    check_eq("ar_chan", rr_chan, 0);
    check_eq("ar_data", rr_data, 0);
    check_eq("ar_en", rr_en, 0);
    check_eq("ar_ovf", rr_ovf, 0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq($sformatf("ar_post_dv%0d", k), rr_dv, 0);
    end
    cfg_write(16'h0001, 16'd1, 48'd1);
    dv = 5'b00010; set_d(1, 18'h155);
    tick();
    dv = '0;
    tick();
    check_eq("ar_new_dv", rr_dv, 1);
    check_eq("ar_new_chan", rr_chan, 1);
    check_eq("ar_new_data", rr_data, 18'h155);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/chan_arbiter.md
CHAN_ARBITER -- requirements
Module: chan_arbiter

Interface
REQ-001 SHALL have parameter N_CHAN, default 5, number of input sample channels.
REQ-002 SHALL have parameter W_CHAN, default 8, channel index width.
REQ-003 SHALL have parameter W_DATA, default 18, signed sample width.
REQ-004 SHALL have parameters W_WR_ADDR, W_WR_CHAN, W_WR_DATA, defaults 16, 16, 48, write-bus widths.
REQ-005 SHALL have parameter ADDR_CHAN_EN, default 16'h0001, write address of the channel-enable register.
REQ-006 SHALL have parameter ADDR_OVF_CLR, default 16'h0002, write address of the overflow-clear command.
REQ-007 SHALL have parameter RR_MODE, default 1: 1 selects round-robin, 0 selects fixed priority (lowest index wins).
REQ-008 SHALL have clk_in  input  1  sole clock; all state updates on its rising edge.
REQ-009 SHALL have rst_in  input  1  reset, asynchronous and active-high.
REQ-010 SHALL have dv_in  input  N_CHAN  per-channel sample strobe.
REQ-011 SHALL have data_in  input  N_CHAN*W_DATA  packed signed samples; channel i at bits [i*W_DATA +: W_DATA].
REQ-012 SHALL have wr_en / wr_addr / wr_chan / wr_data  input  1 / W_WR_ADDR / W_WR_CHAN / W_WR_DATA  configuration write bus.
REQ-013 SHALL have dv_out  output  1  one-cycle output sample strobe.
REQ-014 SHALL have chan_out  output  W_CHAN  channel index of the output sample.
REQ-015 SHALL have data_out  output  W_DATA  signed output sample.
REQ-016 SHALL have chan_en_out  output  N_CHAN  current channel-enable register.
REQ-017 SHALL have ovf_out  output  N_CHAN  sticky per-channel overflow flags.

Function
REQ-018 SHALL hold one holding register (data + valid) per channel.
REQ-019 SHALL, on dv_in[i] with chan_en[i]=1, load data_in channel i into holding register i and set its valid at the next edge.
REQ-020 SHALL, on dv_in[i] while holding i is valid and not granted this cycle, overwrite the held data and set ovf[i].
REQ-021 SHALL, on dv_in[i] in the same cycle holding i is granted, reload with the new sample, keep valid=1, and leave ovf[i] unchanged.
REQ-022 SHALL ignore dv_in[i] when chan_en[i]=0 and clear valid[i] at each edge while chan_en[i]=0.
REQ-023 SHALL grant at most one valid channel per cycle, combinationally from current valid bits.
REQ-024 SHALL, in RR_MODE=1, search from (last_grant+1) upward, wrapping N_CHAN-1 -> 0, and update last_grant only on a grant.
REQ-025 SHALL, in RR_MODE=0, grant the lowest-index valid channel.
REQ-026 SHALL register the grant: dv_out=1, chan_out=granted index, data_out=held data in the cycle after the grant; dv_out=0 otherwise, with chan_out/data_out holding their last values.
REQ-027 SHALL clear valid of the granted channel at the grant edge unless REQ-021 applies.
REQ-028 SHALL give latency 2 cycles from dv_in (cycle t) to dv_out (cycle t+2) for an uncontended channel.
REQ-029 SHALL, on wr_en with wr_addr=ADDR_CHAN_EN and wr_chan<N_CHAN, set chan_en[wr_chan] to wr_data[0]; writes with wr_chan>=N_CHAN are ignored.
REQ-030 SHALL, on wr_en with wr_addr=ADDR_OVF_CLR and wr_chan<N_CHAN, clear ovf[wr_chan]; a simultaneous overflow event on that channel wins (flag stays set).
REQ-031 SHALL still emit a sample granted in the same cycle its channel is disabled; the disable takes effect at that edge.
REQ-032 SHALL sustain one output per cycle when multiple channels are valid, with no sample loss except per REQ-020.

Reset
REQ-033 SHALL, while rst_in=1, force dv_out=0, chan_out=0, data_out=0, chan_en=0, ovf=0, all valid=0, and last_grant=N_CHAN-1.
REQ-034 SHALL resume normal operation at the first rising edge after rst_in deasserts; samples in flight at reset assertion are discarded.

Verification
REQ-035 SHALL verify: enable ch2, dv_in[2] with data 18'h1234 at cycle t -> dv_out=1, chan_out=2, data_out=18'h1234 at cycle t+2 only.
REQ-036 SHALL verify: RR_MODE=1, all 5 channels enabled, all dv_in asserted in one cycle -> chan_out sequence 0,1,2,3,4 on five consecutive cycles, ovf_out=0.
REQ-037 SHALL verify: RR_MODE=0, ch0 and ch3 strobed every cycle -> only ch0 output each cycle, ovf_out[3]=1, ovf_out[0]=0.
REQ-038 SHALL verify: dv_in[1] with ch1 disabled -> no dv_out, ovf_out=0; write ADDR_CHAN_EN wr_chan=7 -> chan_en_out unchanged.
REQ-039 SHALL verify: ovf_out[4]=1, ADDR_OVF_CLR write on ch4 coincident with a fresh overflow on ch4 -> ovf_out[4] stays 1; clear alone next cycle -> 0.
REQ-040 SHALL verify: rst_in asserted mid-stream with three channels valid -> outputs and flags 0 immediately (asynchronously), no dv_out after release until new dv_in.
